fadder_pipe: RTL and testbench
==============================

// Module: fadder_pipe
// PURPOSE
//  Parametrised, pipelined adder/subtractor; successor to the single-stage full adder/subtractor.
//  Adds a valid/ready handshake on both sides, configurable pipeline depth, four arithmetic modes
//  and status flags. Sits between an operand source (sequencer/FIFO) and a result consumer.
// PARAMETERS
//  DATA_WIDTH   8  operand/result width in bits; legal range >= 2
//  PIPE_STAGES  2  number of register stages = latency in cycles with no stall; legal range >= 1
// PORTS
//  clk        in   1           clock; all state updates on rising edge
//  reset_n    in   1           asynchronous, active-low reset
//  in_vld     in   1           operand beat valid
//  in_rdy     out  1           block can accept an operand beat this cycle
//  mode       in   2           00 SUB, 01 ADD, 10 ADDC (add with carry), 11 SUBB (subtract with borrow)
//  op_a       in   DATA_WIDTH  operand A (unsigned; signed view used only for overflow)
//  op_b       in   DATA_WIDTH  operand B
//  carry_in   in   1           carry (ADDC) or borrow (SUBB); ignored in ADD and SUB
//  out_vld    out  1           result beat valid
//  out_rdy    in   1           consumer accepts result beat this cycle
//  data_out   out  DATA_WIDTH  result
//  carry_out  out  1           carry (ADD/ADDC) or borrow (SUB/SUBB)
//  ovf_out    out  1           two's-complement signed overflow
//  zero_out   out  1           data_out == 0
// BEHAVIOUR
//  Reset: while reset_n low, all stage valid bits, data and flags clear to 0 immediately.
//   out_vld=0, data_out=0, carry_out=0, ovf_out=0, zero_out=0, in_rdy=0.
//   in_rdy rises in the first cycle after reset_n deasserts.
//   Reset mid-operation discards all in-flight beats; no partial result is ever emitted.
//  Transfers: input beat accepted when in_vld && in_rdy at a clock edge.
//   Output beat consumed when out_vld && out_rdy at a clock edge.
//  Arithmetic: computed combinationally from accepted inputs and captured into stage 1.
//   Stages 2..PIPE_STAGES only move the result and flags.
//   Computation uses a (DATA_WIDTH+1)-bit sum; data = low DATA_WIDTH bits.
//   ADD:  {c,d} = a + b
//   ADDC: {c,d} = a + b + cin
//   SUB:  d = a - b;       carry_out = (b > a), unsigned borrow
//   SUBB: d = a - b - cin; carry_out = ((b + cin) > a), compare at DATA_WIDTH+1 bits
//   Overflow, add modes: a[msb]==b[msb] && d[msb]!=a[msb]
//   Overflow, sub modes: a[msb]!=b[msb] && d[msb]!=a[msb]
//   zero_out = (d == 0), all modes.
//  Pipeline flow, bubble-collapsing:
//   stage k loads from stage k-1 when stage k is empty or stage k is advancing;
//   last stage advances when out_rdy.
//   in_rdy = !stage1_vld || stage1 advancing.
//   Combinational path out_rdy -> in_rdy is permitted.
//   out_vld/data_out/flags are driven directly by the last stage's registers.
//   Output is held stable while out_vld && !out_rdy.
//  Latency: PIPE_STAGES cycles from acceptance to out_vld, with no stall.
//   Throughput: 1 beat/cycle when out_rdy is held high.
//   Capacity: PIPE_STAGES beats when out_rdy is held low; in_rdy=0 once all stages are full.
//  Ordering: results leave in acceptance order; no beat dropped or duplicated.
//  Simultaneous accept and emit when full: legal; occupancy unchanged.
//  Signals with in_vld=0 are don't-care; mode/carry_in/operands are sampled only on acceptance.
// TESTING
//  (DATA_WIDTH=8, PIPE_STAGES=2 unless stated)
//  1. ADD F0+20, out_rdy=1 -> 2 cycles later data_out=10, carry_out=1, ovf=0, zero=0.
//  2. SUB 05-07 -> data_out=FE, carry_out=1. SUBB 07-05, cin=1 -> 01, carry_out=0.
//  3. ADD 7F+01 -> 80, ovf=1. ADDC FF+00, cin=1 -> 00, carry_out=1, zero=1.
//  4. PIPE_STAGES=4, out_rdy=0, stream 6 beats:
//     4 accepted then in_rdy=0; raise out_rdy -> 4 results in order, then 2 more, no gaps.
//  5. Random in_vld/out_rdy, 10k beats vs reference model -> every result matches, in order.
//  6. Assert reset_n mid-stream with 2 beats in flight -> out_vld=0 immediately;
//     after release no stale beat; new beat has latency=PIPE_STAGES.

Source files
------------

// File: rtl/fadder_pipe_if.sv
// Operand and result handshake bundle for fadder_pipe.
// The slave modport is the adder's view; the master modport is the source/consumer side.
interface fadder_pipe_if #(
    parameter int DATA_WIDTH = 8
);
    logic                  in_vld;
    logic                  in_rdy;
    logic [1:0]            mode;
    logic [DATA_WIDTH-1:0] op_a;
    logic [DATA_WIDTH-1:0] op_b;
    logic                  carry_in;
    logic                  out_vld;
    logic                  out_rdy;
    logic [DATA_WIDTH-1:0] data_out;
    logic                  carry_out;
    logic                  ovf_out;
    logic                  zero_out;

    modport slave (
        input  in_vld, mode, op_a, op_b, carry_in, out_rdy,
        output in_rdy, out_vld, data_out, carry_out, ovf_out, zero_out
    );

    modport master (
        output in_vld, mode, op_a, op_b, carry_in, out_rdy,
        input  in_rdy, out_vld, data_out, carry_out, ovf_out, zero_out
    );
endinterface

// File: rtl/fadder_pipe.sv
// Pipelined adder/subtractor with valid/ready on both sides and bubble-collapsing stages.
// Arithmetic happens before stage 1; later stages only carry {zero, ovf, carry, data}.
module fadder_pipe #(
    parameter int DATA_WIDTH  = 8,
    parameter int PIPE_STAGES = 2
) (
    input  logic         clk,
    input  logic         reset_n,
    fadder_pipe_if.slave bus
);
    localparam int         PW        = DATA_WIDTH + 3;
    localparam int         MSB       = DATA_WIDTH - 1;
    localparam logic [1:0] MODE_SUB  = 2'b00;
    localparam logic [1:0] MODE_SUBB = 2'b11;

    logic                   run;
    logic [PIPE_STAGES-1:0] stg_vld;
    logic [PIPE_STAGES-1:0] stg_load;
    logic [PW-1:0]          stg_pay [PIPE_STAGES];
    logic                   tail_full;
    logic                   accept;
    logic                   is_sub;
    logic                   cin_eff;
    logic [DATA_WIDTH:0]    a_x;
    logic [DATA_WIDTH:0]    b_x;
    logic [DATA_WIDTH:0]    c_x;
    logic [DATA_WIDTH:0]    res_x;
    logic [DATA_WIDTH-1:0]  res_d;
    logic                   res_c;
    logic                   res_v;
    logic                   res_z;
    logic [PW-1:0]          new_pay;

    // A stage can load unless it and every stage after it are full while the consumer stalls.
    always_comb begin
        stg_load  = '0;
        tail_full = 1'b1;
        for (int k = 0; k < PIPE_STAGES; k++) begin
            tail_full = 1'b1;
            for (int j = k; j < PIPE_STAGES; j++) begin
                tail_full = tail_full & stg_vld[j];
            end
            stg_load[k] = !tail_full || bus.out_rdy;
        end
    end

    assign bus.in_rdy = run && stg_load[0];
    assign accept     = bus.in_vld && bus.in_rdy;

    // Subtract at DATA_WIDTH+1 bits so the top bit is the borrow of a - (b + cin).
    assign is_sub  = (bus.mode == MODE_SUB) || (bus.mode == MODE_SUBB);
    assign cin_eff = bus.mode[1] & bus.carry_in;
    assign a_x     = {1'b0, bus.op_a};
    assign b_x     = {1'b0, bus.op_b};
    assign c_x     = {{DATA_WIDTH{1'b0}}, cin_eff};
    assign res_x   = is_sub ? (a_x - b_x - c_x) : (a_x + b_x + c_x);
    assign res_d   = res_x[DATA_WIDTH-1:0];
    assign res_c   = res_x[DATA_WIDTH];
    assign res_v   = ((bus.op_a[MSB] ^ bus.op_b[MSB]) == is_sub) && (res_d[MSB] != bus.op_a[MSB]);
    assign res_z   = (res_d == '0);
    assign new_pay = {res_z, res_v, res_c, res_d};

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            run     <= 1'b0;
            stg_vld <= '0;
            for (int k = 0; k < PIPE_STAGES; k++) begin
                stg_pay[k] <= '0;
            end
        end else begin
            run <= 1'b1;
            if (stg_load[0]) begin
                stg_vld[0] <= accept;
                if (accept) begin
                    stg_pay[0] <= new_pay;
                end
            end
            for (int k = 1; k < PIPE_STAGES; k++) begin
                if (stg_load[k]) begin
                    stg_vld[k] <= stg_vld[k-1];
                    if (stg_vld[k-1]) begin
                        stg_pay[k] <= stg_pay[k-1];
                    end
                end
            end
        end
    end

    assign bus.out_vld   = stg_vld[PIPE_STAGES-1];
    assign bus.zero_out  = stg_pay[PIPE_STAGES-1][PW-1];
    assign bus.ovf_out   = stg_pay[PIPE_STAGES-1][PW-2];
    assign bus.carry_out = stg_pay[PIPE_STAGES-1][PW-3];
    assign bus.data_out  = stg_pay[PIPE_STAGES-1][DATA_WIDTH-1:0];
endmodule

// File: tb/tb_fadder_pipe.sv
// Scoreboard bench for fadder_pipe: instance 0 has 2 stages, instance 1 has 4 stages.
// Expected results are queued on acceptance and popped by per-instance output monitors.
module tb_fadder_pipe;
    localparam logic [1:0] M_SUB  = 2'b00;
    localparam logic [1:0] M_ADD  = 2'b01;
    localparam logic [1:0] M_ADDC = 2'b10;
    localparam logic [1:0] M_SUBB = 2'b11;

    logic            clk = 1'b0;
    logic            reset_n;
    logic [1:0]      in_vld_s;
    logic [1:0]      in_rdy_s;
    logic [1:0]      carry_in_s;
    logic [1:0]      out_vld_s;
    logic [1:0]      out_rdy_s;
    logic [1:0]      c_s;
    logic [1:0]      v_s;
    logic [1:0]      z_s;
    logic [1:0][1:0] mode_s;
    logic [1:0][7:0] a_s;
    logic [1:0][7:0] b_s;
    logic [1:0][7:0] d_s;
    logic [10:0]     exp_q [2][$];
    int              checks = 0;
    int              errors = 0;

    logic [1:0]  t4m [6] = '{M_ADD, M_ADD, M_SUB, M_ADD, M_SUB, M_ADDC};
    logic [7:0]  t4a [6] = '{8'h01, 8'h10, 8'h50, 8'hFF, 8'h00, 8'h40};
    logic [7:0]  t4b [6] = '{8'h01, 8'h20, 8'h10, 8'h01, 8'h01, 8'h3F};
    logic        t4c [6] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    logic [10:0] t4e [6] = '{11'h002, 11'h030, 11'h040, 11'h500, 11'h1FF, 11'h280};

    always #5 clk = ~clk;

    task automatic check(string name, logic [31:0] got, logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    function automatic logic [10:0] pk(logic z, logic v, logic c, logic [7:0] d);
        return {z, v, c, d};
    endfunction

    // Integer reference: unsigned result for data/carry, signed range test for overflow.
    function automatic logic [10:0] model(logic [1:0] m, logic [7:0] a, logic [7:0] b, logic ci);
        int ia = int'(a);
        int ib = int'(b);
        int sa = (a > 8'd127) ? ia - 256 : ia;
        int sb = (b > 8'd127) ? ib - 256 : ib;
        int c  = m[1] ? int'(ci) : 0;
        int r;
        int sr;
        logic carry;
        logic [7:0] d;
        if (m == M_ADD || m == M_ADDC) begin
            r     = ia + ib + c;
            sr    = sa + sb + c;
            carry = (r > 255);
        end else begin
            r     = ia - ib - c;
            sr    = sa - sb - c;
            carry = (r < 0);
        end
        d = r[7:0];
        return {(d == 8'h00), (sr > 127 || sr < -128), carry, d};
    endfunction

    generate
        for (genvar g = 0; g < 2; g++) begin : g_dut
            fadder_pipe_if #(.DATA_WIDTH(8)) u_if ();

            assign u_if.in_vld   = in_vld_s[g];
            assign u_if.mode     = mode_s[g];
            assign u_if.op_a     = a_s[g];
            assign u_if.op_b     = b_s[g];
            assign u_if.carry_in = carry_in_s[g];
            assign u_if.out_rdy  = out_rdy_s[g];
            assign in_rdy_s[g]   = u_if.in_rdy;
            assign out_vld_s[g]  = u_if.out_vld;
            assign d_s[g]        = u_if.data_out;
            assign c_s[g]        = u_if.carry_out;
            assign v_s[g]        = u_if.ovf_out;
            assign z_s[g]        = u_if.zero_out;

            fadder_pipe #(
                .DATA_WIDTH (8),
                .PIPE_STAGES(g == 0 ? 2 : 4)
            ) u_dut (
                .clk    (clk),
                .reset_n(reset_n),
                .bus    (u_if)
            );

            logic        held = 1'b0;
            logic [10:0] held_pay;
            logic [10:0] got;

            always @(negedge clk) begin
                if (!reset_n) begin
                    held = 1'b0;
                end else begin
                    got = {z_s[g], v_s[g], c_s[g], d_s[g]};
                    if (held) begin
                        check($sformatf("hold_d%0d", g), {out_vld_s[g], got}, {1'b1, held_pay});
                    end
                    if (out_vld_s[g]) begin
                        if (out_rdy_s[g]) begin
                            if (exp_q[g].size() == 0) begin
                                check($sformatf("spurious_beat_d%0d", g), exp_q[g].size(), 1);
                            end else begin
                                check($sformatf("result_d%0d", g), got, exp_q[g].pop_front());
                            end
                        end
                        held     = !out_rdy_s[g];
                        held_pay = got;
                    end else begin
                        held = 1'b0;
                    end
                end
            end
        end
    endgenerate

    task automatic drive(int g, logic [1:0] m, logic [7:0] a, logic [7:0] b, logic ci);
        mode_s[g]     = m;
        a_s[g]        = a;
        b_s[g]        = b;
        carry_in_s[g] = ci;
    endtask

    // Presents one beat, queues its expectation on acceptance, returns 1ns after the accept edge.
    task automatic send(int g, logic [1:0] m, logic [7:0] a, logic [7:0] b, logic ci, logic [10:0] e);
        int w = 0;
        drive(g, m, a, b, ci);
        in_vld_s[g] = 1'b1;
        @(negedge clk);
        while (!in_rdy_s[g] && w < 50) begin
            @(negedge clk);
            w++;
        end
        check($sformatf("accept_d%0d", g), in_rdy_s[g], 1);
        if (in_rdy_s[g]) exp_q[g].push_back(e);
        @(posedge clk);
        #1;
        in_vld_s[g] = 1'b0;
    endtask

    task automatic send_lat(int g, logic [1:0] m, logic [7:0] a, logic [7:0] b, logic ci,
                            logic [10:0] e, int lat);
        int n = 1;
        send(g, m, a, b, ci, e);
        while (!out_vld_s[g] && n < 20) begin
            @(posedge clk);
            #1;
            n++;
        end
        check($sformatf("latency_d%0d", g), n, lat);
    endtask

    task automatic wait_drain(int g);
        int w = 0;
        while (exp_q[g].size() != 0 && w < 200) begin
            @(posedge clk);
            w++;
        end
        #1;
        check($sformatf("drain_d%0d", g), exp_q[g].size(), 0);
    endtask

    initial begin
        int gaps;
        int idx;
        int acc;
        int cyc_n;
        int stale;
        logic [7:0] corner [4];
        corner = '{8'h00, 8'h7F, 8'h80, 8'hFF};

        reset_n    = 1'b0;
        in_vld_s   = '0;
        out_rdy_s  = 2'b11;
        carry_in_s = '0;
        mode_s     = '0;
        a_s        = '0;
        b_s        = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        for (int g = 0; g < 2; g++) begin
            check($sformatf("reset_state_d%0d", g),
                  {in_rdy_s[g], out_vld_s[g], z_s[g], v_s[g], c_s[g], d_s[g]}, 0);
        end
        @(posedge clk);
        #1 reset_n = 1'b1;
        @(posedge clk);
        #1;
        for (int g = 0; g < 2; g++) check($sformatf("rdy_after_reset_d%0d", g), in_rdy_s[g], 1);

        // Directed arithmetic on the 2-stage instance
        send_lat(0, M_ADD, 8'hF0, 8'h20, 1'b0, pk(0, 0, 1, 8'h10), 2);
        send(0, M_SUB,  8'h05, 8'h07, 1'b0, pk(0, 0, 1, 8'hFE));
        send(0, M_SUBB, 8'h07, 8'h05, 1'b1, pk(0, 0, 0, 8'h01));
        send(0, M_ADD,  8'h7F, 8'h01, 1'b0, pk(0, 1, 0, 8'h80));
        send(0, M_ADDC, 8'hFF, 8'h00, 1'b1, pk(1, 0, 1, 8'h00));
        send(0, M_SUB,  8'h80, 8'h01, 1'b0, pk(0, 1, 0, 8'h7F));
        send(0, M_SUB,  8'h05, 8'h05, 1'b0, pk(1, 0, 0, 8'h00));
        send(0, M_ADD,  8'h01, 8'h01, 1'b1, pk(0, 0, 0, 8'h02));
        send(0, M_SUB,  8'h05, 8'h03, 1'b1, pk(0, 0, 0, 8'h02));
        send(0, M_SUBB, 8'h05, 8'h05, 1'b1, pk(0, 0, 1, 8'hFF));
        send(0, M_ADDC, 8'h7F, 8'h00, 1'b1, pk(0, 1, 0, 8'h80));
        send(0, M_SUBB, 8'h00, 8'hFF, 1'b1, pk(1, 0, 1, 8'h00));
        send(0, M_ADD,  8'h80, 8'h80, 1'b0, pk(1, 1, 1, 8'h00));
        wait_drain(0);

        // Capacity and stall release on the 4-stage instance
        out_rdy_s[1] = 1'b0;
        for (int i = 0; i < 4; i++) send(1, t4m[i], t4a[i], t4b[i], t4c[i], t4e[i]);
        drive(1, t4m[4], t4a[4], t4b[4], t4c[4]);
        in_vld_s[1] = 1'b1;
        repeat (2) begin
            @(negedge clk);
            check("full_in_rdy", in_rdy_s[1], 0);
        end
        @(posedge clk);
        #1 out_rdy_s[1] = 1'b1;
        idx  = 4;
        gaps = 0;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            if (!out_vld_s[1]) gaps++;
            if (in_vld_s[1] && in_rdy_s[1]) begin
                exp_q[1].push_back(t4e[idx]);
                idx++;
            end
            @(posedge clk);
            #1;
            if (idx < 6) drive(1, t4m[idx], t4a[idx], t4b[idx], t4c[idx]);
            else in_vld_s[1] = 1'b0;
        end
        check("stream_gaps", gaps, 0);
        check("stream_accepted", idx, 6);
        wait_drain(1);

        // Random handshake traffic against the integer model
        acc   = 0;
        cyc_n = 0;
        while (acc < 10000 && cyc_n < 40000) begin
            in_vld_s[0]   = ($urandom_range(3) != 0);
            out_rdy_s[0]  = ($urandom_range(3) != 0);
            mode_s[0]     = 2'($urandom_range(3));
            a_s[0]        = ($urandom_range(3) == 0) ? corner[$urandom_range(3)] : 8'($urandom);
            b_s[0]        = ($urandom_range(3) == 0) ? corner[$urandom_range(3)] : 8'($urandom);
            carry_in_s[0] = 1'($urandom_range(1));
            @(negedge clk);
            if (in_vld_s[0] && in_rdy_s[0]) begin
                exp_q[0].push_back(model(mode_s[0], a_s[0], b_s[0], carry_in_s[0]));
                acc++;
            end
            @(posedge clk);
            #1;
            cyc_n++;
        end
        check("random_beats", acc, 10000);
        in_vld_s[0]  = 1'b0;
        out_rdy_s[0] = 1'b1;
        wait_drain(0);

        // Reset with two beats in flight
        out_rdy_s[0] = 1'b0;
        send(0, M_ADD, 8'h11, 8'h22, 1'b0, pk(0, 0, 0, 8'h33));
        send(0, M_ADD, 8'h44, 8'h11, 1'b0, pk(0, 0, 0, 8'h55));
        check("inflight_vld", out_vld_s[0], 1);
        #2 reset_n = 1'b0;
        #1;
        check("async_reset_clear",
              {in_rdy_s[0], out_vld_s[0], z_s[0], v_s[0], c_s[0], d_s[0]}, 0);
        exp_q[0].delete();
        repeat (2) @(posedge clk);
        #1;
        reset_n      = 1'b1;
        out_rdy_s[0] = 1'b1;
        @(posedge clk);
        #1;
        check("rdy_after_midreset", in_rdy_s[0], 1);
        stale = 0;
        repeat (4) begin
            @(negedge clk);
            if (out_vld_s[0]) stale++;
        end
        check("no_stale_beat", stale, 0);
        @(posedge clk);
        #1;
        send_lat(0, M_SUBB, 8'h10, 8'h01, 1'b1, pk(0, 0, 0, 8'h0E), 2);
        wait_drain(0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
